// File: rtl/ddr3_pg_rr_arbiter_pkg.sv
// Shared definitions for the DDR3 page-transfer arbiter: FSM encoding, default page
// address width and an index-width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ddr3_pg_rr_arbiter_pkg;

  localparam int L_DDR3_PG_ADDR_WIDTH = 28;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RELEASE  = 2'd3
  } arb_state_t;

  // Width of a requester index. A single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr3_pg_rr_arbiter_rr_pick.sv
// Round-robin pick: first pending index after 'last', wrapping modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to use the result.
//  pending  in  N_REQ  candidate request vector
//  last     in  IW     index served most recently (the scan starts at last+1)
//  winner   out IW     chosen index, 0 when nothing is found
//  found    out 1      at least one pending bit was set
module ddr3_pg_rr_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    winner,
  output logic             found
);

  logic [IW-1:0] pos;

  // Scan from the farthest position back to last+1 so the nearest pending
  // index after 'last' is the final (winning) assignment.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      pos = IW'((int'(last) + k) % N_REQ);
      if (pending[pos]) begin
        winner = pos;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_pg_rr_arbiter.sv
// Shares the DDR3 page-transfer engine among N_REQ requesters: round robin with a high-priority class.
// Latency: request seen in IDLE -> ddr3_pg_req 2 cycles later; engine ack -> requester ack 1 cycle later.
// Backpressure: requesters hold req_pg_req until their ack; the engine is held off by ddr3_pg_req/ddr3_pg_ack.
//  clk, rst                       DDR3 UI clock, async active-high reset
//  req_pg_req/optype/addr         per-requester level request, op (1 = write) and page address
//  req_pg_ack                     one-cycle ack pulse to the granted requester
//  pri_mask                       1 = requester belongs to the high-priority class
//  to_cycles, err_clr             ack timeout threshold (0 disables), clear for the sticky error
//  ddr3_pg_req/optype/addr/ack    handshake with the page-transfer engine
//  grant_valid, grant_idx         outstanding grant and its (or the last) index
//  timeout_err, n_xfers           sticky timeout flag, wrapping completed-transfer count
module ddr3_pg_rr_arbiter
  import ddr3_pg_rr_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int P_ADDR_WIDTH = L_DDR3_PG_ADDR_WIDTH,
  parameter int P_TO_WIDTH   = 16,
  localparam int IW          = idx_width(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_pg_req,
  input  logic [N_REQ-1:0]          req_pg_optype,
  input  logic [N_REQ*P_ADDR_WIDTH-1:0] req_pg_addr,
  output logic [N_REQ-1:0]          req_pg_ack,
  input  logic [N_REQ-1:0]          pri_mask,
  input  logic [P_TO_WIDTH-1:0]     to_cycles,
  input  logic                      err_clr,
  output logic                      ddr3_pg_req,
  output logic                      ddr3_pg_optype,
  output logic [P_ADDR_WIDTH-1:0]   ddr3_pg_addr,
  input  logic                      ddr3_pg_ack,
  output logic                      grant_valid,
  output logic [IW-1:0]             grant_idx,
  output logic                      timeout_err,
  output logic [15:0]               n_xfers
);

  arb_state_t              state_q, state_d;
  logic [IW-1:0]           last_q, last_d;
  logic [IW-1:0]           gidx_q, gidx_d;
  logic                    gvld_q, gvld_d;
  logic                    pgreq_q, pgreq_d;
  logic                    optype_q, optype_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [N_REQ-1:0]        ack_q, ack_d;
  logic [P_TO_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [15:0]             nx_q, nx_d;

  logic [IW-1:0]           pri_idx, all_idx, win_idx;
  logic                    pri_found, all_found;
  logic [P_ADDR_WIDTH-1:0] addr_sel;
  logic                    optype_sel;
  logic                    req_w;
  logic [P_TO_WIDTH-1:0]   cnt_inc;
  logic                    to_hit;

  // Two pickers share the pointer; the priority class wins whenever it has
  // anyone pending, otherwise the full set is used.
  ddr3_pg_rr_arbiter_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick_pri (
    .pending (req_pg_req & pri_mask),
    .last    (last_q),
    .winner  (pri_idx),
    .found   (pri_found)
  );

  ddr3_pg_rr_arbiter_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick_all (
    .pending (req_pg_req),
    .last    (last_q),
    .winner  (all_idx),
    .found   (all_found)
  );

  assign win_idx = pri_found ? pri_idx : all_idx;

  // Select the winner's address/op and the current grantee's request level.
  always_comb begin
    addr_sel   = '0;
    optype_sel = 1'b0;
    req_w      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        addr_sel   = req_pg_addr[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
        optype_sel = req_pg_optype[i];
      end
      if (gidx_q == IW'(i)) begin
        req_w = req_pg_req[i];
      end
    end
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gidx_d   = gidx_q;
    gvld_d   = gvld_q;
    pgreq_d  = pgreq_q;
    optype_d = optype_q;
    addr_d   = addr_q;
    ack_d    = '0;
    cnt_d    = cnt_q;
    nx_d     = nx_q;
    to_hit   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_pg_req) begin
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // The request may have vanished since IDLE sampled it; fall back.
        if (all_found) begin
          gidx_d   = win_idx;
          gvld_d   = 1'b1;
          pgreq_d  = 1'b1;
          addr_d   = addr_sel;
          optype_d = optype_sel;
          cnt_d    = '0;
          state_d  = ST_WAIT_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_ACK: begin
        // Timeout only flags; the transfer keeps waiting for the engine.
        cnt_d  = cnt_inc;
        to_hit = (to_cycles != '0) && (cnt_inc == to_cycles);
        if (ddr3_pg_ack) begin
          pgreq_d = 1'b0;
          for (int i = 0; i < N_REQ; i++) begin
            ack_d[i] = (gidx_q == IW'(i));
          end
          nx_d    = nx_q + 16'd1;
          last_d  = gidx_q;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        // Waiting for the grantee to drop guarantees it cannot win again on
        // the same request.
        if (!req_w) begin
          gvld_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    err_d = to_hit ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_q   <= IW'(N_REQ - 1);
      gidx_q   <= '0;
      gvld_q   <= 1'b0;
      pgreq_q  <= 1'b0;
      optype_q <= 1'b0;
      addr_q   <= '0;
      ack_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      nx_q     <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gidx_q   <= gidx_d;
      gvld_q   <= gvld_d;
      pgreq_q  <= pgreq_d;
      optype_q <= optype_d;
      addr_q   <= addr_d;
      ack_q    <= ack_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      nx_q     <= nx_d;
    end
  end

  assign req_pg_ack     = ack_q;
  assign ddr3_pg_req    = pgreq_q;
  assign ddr3_pg_optype = optype_q;
  assign ddr3_pg_addr   = addr_q;
  assign grant_valid    = gvld_q;
  assign grant_idx      = gidx_q;
  assign timeout_err    = err_q;
  assign n_xfers        = nx_q;

endmodule

// File: tb/tb_ddr3_pg_rr_arbiter.sv
// Self-checking bench for ddr3_pg_rr_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level model of the arbitration rules.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
module tb_ddr3_pg_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 28;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, optype, pri;
  logic [AW-1:0] addr_v [N];
  logic [N*AW-1:0] addr_bus;
  logic [TW-1:0] to_cycles;
  logic          err_clr, pg_ack;

  logic [N-1:0]  req_pg_ack;
  logic          ddr3_pg_req, ddr3_pg_optype, grant_valid, timeout_err;
  logic [AW-1:0] ddr3_pg_addr;
  logic [1:0]    grant_idx;
  logic [15:0]   n_xfers;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign addr_bus = {addr_v[3], addr_v[2], addr_v[1], addr_v[0]};

  ddr3_pg_rr_arbiter #(.N_REQ(N), .P_ADDR_WIDTH(AW), .P_TO_WIDTH(TW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_pg_req     (req),
    .req_pg_optype  (optype),
    .req_pg_addr    (addr_bus),
    .req_pg_ack     (req_pg_ack),
    .pri_mask       (pri),
    .to_cycles      (to_cycles),
    .err_clr        (err_clr),
    .ddr3_pg_req    (ddr3_pg_req),
    .ddr3_pg_optype (ddr3_pg_optype),
    .ddr3_pg_addr   (ddr3_pg_addr),
    .ddr3_pg_ack    (pg_ack),
    .grant_valid    (grant_valid),
    .grant_idx      (grant_idx),
    .timeout_err    (timeout_err),
    .n_xfers        (n_xfers)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0; optype = '0; pri = '0;
    pg_ack = 1'b0; err_clr = 1'b0; to_cycles = '0;
    for (int i = 0; i < N; i++) addr_v[i] = '0;
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int c;
    c = 0;
    while (!ddr3_pg_req && c < 30) begin
      tick();
      c++;
    end
    chk({tag, "_seen"}, 32'(ddr3_pg_req), 32'd1);
  endtask

  // Waits for a grant, checks the winner, acks after dly cycles, then the
  // winner drops for one edge and optionally re-requests.
  task automatic do_xfer(input string tag, input int w, input int dly, input bit rehold);
    wait_req(tag);
    chk({tag, "_idx"}, 32'(grant_idx), 32'(w));
    chk({tag, "_vld"}, 32'(grant_valid), 32'd1);
    repeat (dly) tick();
    pg_ack = 1'b1;
    tick();
    pg_ack = 1'b0;
    chk({tag, "_ack"}, 32'(req_pg_ack), 32'd1 << w);
    req[w] = 1'b0;
    tick();
    req[w] = rehold;
  endtask

  // Selection rule straight from the arbitration policy.
  function automatic int pick(input logic [N-1:0] pend, input logic [N-1:0] pm, input int last);
    logic [N-1:0] cand;
    cand = ((pend & pm) != '0) ? (pend & pm) : pend;
    for (int k = 1; k <= N; k++) begin
      if (cand[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Randomized-run state: model and bench-side agents.
  logic [N-1:0]  b_req, b_pri, exp_ack;
  logic          b_ack, b_clr, b_pg, hit;
  logic [TW-1:0] b_to;
  int m_last, m_nx, m_cnt, m_w, timer;
  logic m_err;

  initial begin
    rst = 1'b1;
    req = '0; optype = '0; pri = '0;
    pg_ack = 1'b0; err_clr = 1'b0; to_cycles = '0;
    for (int i = 0; i < N; i++) addr_v[i] = '0;
    #3;
    chk("rst_pgreq", 32'(ddr3_pg_req), 32'd0);
    chk("rst_gvld",  32'(grant_valid), 32'd0);
    chk("rst_idx",   32'(grant_idx), 32'd0);
    chk("rst_ack",   32'(req_pg_ack), 32'd0);
    chk("rst_addr",  32'(ddr3_pg_addr), 32'd0);
    chk("rst_err",   32'(timeout_err), 32'd0);
    chk("rst_nx",    32'(n_xfers), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: single request, latency and routing
    req[2] = 1'b1; addr_v[2] = 28'h0ABCDEF; optype[2] = 1'b1;
    tick();
    chk("t1_lat1", 32'(ddr3_pg_req), 32'd0);
    tick();
    chk("t1_req",  32'(ddr3_pg_req), 32'd1);
    chk("t1_addr", 32'(ddr3_pg_addr), 32'h0ABCDEF);
    chk("t1_op",   32'(ddr3_pg_optype), 32'd1);
    chk("t1_idx",  32'(grant_idx), 32'd2);
    tick(); tick();
    pg_ack = 1'b1;
    tick();
    pg_ack = 1'b0;
    chk("t1_ack",  32'(req_pg_ack), 32'h4);
    chk("t1_nx",   32'(n_xfers), 32'd1);
    chk("t1_drop", 32'(ddr3_pg_req), 32'd0);
    req[2] = 1'b0;
    tick();
    chk("t1_gvld", 32'(grant_valid), 32'd0);

    // 2: all four pending, fair rotation
    do_reset();
    req = 4'hF;
    do_xfer("t2_g0", 0, 5, 1'b1);
    do_xfer("t2_g1", 1, 5, 1'b1);
    do_xfer("t2_g2", 2, 5, 1'b1);
    do_xfer("t2_g3", 3, 5, 1'b1);
    do_xfer("t2_g4", 0, 5, 1'b0);
    req = '0;
    chk("t2_nx", 32'(n_xfers), 32'd5);
    tick();

    // 3: priority class
    do_reset();
    req = 4'b1011; pri = 4'b1000;
    do_xfer("t3_p3", 3, 2, 1'b0);
    do_xfer("t3_p0", 0, 2, 1'b0);
    do_xfer("t3_p1", 1, 2, 1'b0);
    tick();

    // 4: timeout without abort
    do_reset();
    to_cycles = 16'd10;
    req[1] = 1'b1; addr_v[1] = 28'h1234567;
    wait_req("t4");
    repeat (9) tick();
    chk("t4_err_early", 32'(timeout_err), 32'd0);
    tick();
    chk("t4_err_set",   32'(timeout_err), 32'd1);
    chk("t4_req_held",  32'(ddr3_pg_req), 32'd1);
    repeat (5) tick();
    chk("t4_err_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr",  32'(timeout_err), 32'd0);
    chk("t4_req_held2", 32'(ddr3_pg_req), 32'd1);
    chk("t4_addr",     32'(ddr3_pg_addr), 32'h1234567);
    pg_ack = 1'b1;
    tick();
    pg_ack = 1'b0;
    chk("t4_ack", 32'(req_pg_ack), 32'h2);
    chk("t4_nx",  32'(n_xfers), 32'd1);
    req[1] = 1'b0;
    tick();
    to_cycles = '0;

    // 5: requester drops mid-transfer; spurious engine ack
    do_reset();
    req[1] = 1'b1; addr_v[1] = 28'h0000F0F;
    wait_req("t5");
    tick(); tick();
    req[1] = 1'b0;
    tick(); tick();
    chk("t5_addr_held", 32'(ddr3_pg_addr), 32'h0000F0F);
    pg_ack = 1'b1;
    tick();
    pg_ack = 1'b0;
    chk("t5_ack",  32'(req_pg_ack), 32'h2);
    chk("t5_gvld", 32'(grant_valid), 32'd1);
    tick();
    chk("t5_idle", 32'(grant_valid), 32'd0);
    pg_ack = 1'b1;
    tick();
    pg_ack = 1'b0;
    chk("t5_spur_ack", 32'(req_pg_ack), 32'd0);
    chk("t5_spur_nx",  32'(n_xfers), 32'd1);
    chk("t5_spur_req", 32'(ddr3_pg_req), 32'd0);
    tick();

    // 6: reset in the middle of a transfer
    req[2] = 1'b1; addr_v[2] = 28'hFFFFFFF; optype[2] = 1'b1;
    wait_req("t6");
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_pgreq", 32'(ddr3_pg_req), 32'd0);
    chk("t6_gvld",  32'(grant_valid), 32'd0);
    chk("t6_idx",   32'(grant_idx), 32'd0);
    chk("t6_addr",  32'(ddr3_pg_addr), 32'd0);
    chk("t6_op",    32'(ddr3_pg_optype), 32'd0);
    chk("t6_nx",    32'(n_xfers), 32'd0);
    req = 4'b0011;
    rst = 1'b0;
    do_xfer("t6_g0", 0, 2, 1'b0);
    do_xfer("t6_g1", 1, 2, 1'b0);
    tick();

    // Randomized traffic against the model
    do_reset();
    to_cycles = 16'd6;
    m_last = N - 1; m_nx = 0; m_cnt = 0; m_w = 0; timer = 0; m_err = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      b_req = req; b_pri = pri; b_ack = pg_ack; b_clr = err_clr;
      b_pg = ddr3_pg_req; b_to = to_cycles;
      tick();
      exp_ack = '0;
      hit = 1'b0;
      if (b_pg) begin
        if (m_cnt < 32'hFFFF) m_cnt++;
        hit = (b_to != '0) && (m_cnt == int'(b_to));
        if (b_ack) begin
          exp_ack = N'(1) << m_w;
          m_nx    = (m_nx + 1) & 32'hFFFF;
          m_last  = m_w;
        end
        chk("r_pgreq", 32'(ddr3_pg_req), 32'(!b_ack));
      end else if (ddr3_pg_req) begin
        m_w   = pick(b_req, b_pri, m_last);
        m_cnt = 0;
        timer = $urandom_range(0, 12);
        chk("r_idx", 32'(grant_idx), 32'(m_w));
      end
      m_err = hit ? 1'b1 : (b_clr ? 1'b0 : m_err);
      chk("r_ack", 32'(req_pg_ack), 32'(exp_ack));
      chk("r_nx",  32'(n_xfers), 32'(m_nx));
      chk("r_err", 32'(timeout_err), 32'(m_err));
      if (ddr3_pg_req && m_w >= 0) begin
        chk("r_addr", 32'(ddr3_pg_addr), 32'(addr_v[m_w]));
        chk("r_op",   32'(ddr3_pg_optype), 32'(optype[m_w]));
        chk("r_gvld", 32'(grant_valid), 32'd1);
      end

      // engine: ack after a random delay, occasional stray pulses when idle
      pg_ack = 1'b0;
      if (ddr3_pg_req) begin
        if (timer == 0) pg_ack = 1'b1;
        else timer--;
      end else begin
        pg_ack = ($urandom_range(0, 15) == 0);
      end
      // requesters: hold until acked, then drop and maybe return later
      for (int i = 0; i < N; i++) begin
        if (req_pg_ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i]    = 1'b1;
          addr_v[i] = AW'($urandom);
          optype[i] = 1'($urandom_range(0, 1));
        end
      end
      if ($urandom_range(0, 31) == 0) pri = N'($urandom);
      if ($urandom_range(0, 199) == 0) to_cycles = TW'($urandom_range(0, 9));
      err_clr = ($urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
